// File: rtl/alu_core.sv
// Two-stage registered 3-bit ALU: stage 1 captures all inputs, stage 2 computes
// the 6-bit result and the blinking invalid-operation LED pattern.
module alu_core #(
  parameter string INPUT_PRIORITY = "A",
  parameter string FULL_ADDER     = "ON"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  A,
  input  logic [2:0]  B,
  input  logic [2:0]  opcode,
  input  logic        cin,
  input  logic        serial_in,
  input  logic        direction,
  input  logic        red_op_A,
  input  logic        red_op_B,
  input  logic        bypass_A,
  input  logic        bypass_B,
  output logic [5:0]  out,
  output logic [15:0] leds
);

  typedef enum logic [2:0] {
    OP_AND    = 3'd0,
    OP_XOR    = 3'd1,
    OP_ADD    = 3'd2,
    OP_MUL    = 3'd3,
    OP_SHIFT  = 3'd4,
    OP_ROTATE = 3'd5,
    OP_INV6   = 3'd6,
    OP_INV7   = 3'd7
  } opcode_e;

  localparam bit PRIO_A  = (INPUT_PRIORITY == "A");
  localparam bit FULL_ON = (FULL_ADDER == "ON");

  logic [2:0] a_r, b_r;
  opcode_e    op_r;
  logic       cin_r, serial_in_r, direction_r;
  logic       red_a_r, red_b_r, bypass_a_r, bypass_b_r;

  logic [5:0]  out_next;
  logic [15:0] leds_next;
  logic [2:0]  byp_operand;
  logic        use_red_a;
  logic        invalid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_r         <= '0;
      b_r         <= '0;
      op_r        <= OP_AND;
      cin_r       <= 1'b0;
      serial_in_r <= 1'b0;
      direction_r <= 1'b0;
      red_a_r     <= 1'b0;
      red_b_r     <= 1'b0;
      bypass_a_r  <= 1'b0;
      bypass_b_r  <= 1'b0;
    end else begin
      a_r         <= A;
      b_r         <= B;
      op_r        <= opcode_e'(opcode);
      cin_r       <= cin;
      serial_in_r <= serial_in;
      direction_r <= direction;
      red_a_r     <= red_op_A;
      red_b_r     <= red_op_B;
      bypass_a_r  <= bypass_A;
      bypass_b_r  <= bypass_B;
    end
  end

  // When both flags of a pair are set, INPUT_PRIORITY picks the operand.
  always_comb begin
    byp_operand = '0;
    if (bypass_a_r && bypass_b_r) byp_operand = PRIO_A ? a_r : b_r;
    else if (bypass_a_r)          byp_operand = a_r;
    else                          byp_operand = b_r;

    use_red_a = red_a_r && (!red_b_r || PRIO_A);

    invalid = (op_r == OP_INV6) || (op_r == OP_INV7) ||
              ((red_a_r || red_b_r) && (op_r != OP_AND) && (op_r != OP_XOR));
  end

  always_comb begin
    out_next  = out;
    leds_next = '0;
    if (bypass_a_r || bypass_b_r) begin
      out_next = {3'b000, byp_operand};
    end else if (invalid) begin
      out_next  = '0;
      leds_next = ~leds;
    end else begin
      case (op_r)
        OP_AND: begin
          if (red_a_r || red_b_r) out_next = {5'b0, use_red_a ? &a_r : &b_r};
          else                    out_next = {3'b000, a_r & b_r};
        end
        OP_XOR: begin
          if (red_a_r || red_b_r) out_next = {5'b0, use_red_a ? ^a_r : ^b_r};
          else                    out_next = {3'b000, a_r ^ b_r};
        end
        OP_ADD:
          out_next = {3'b000, a_r} + {3'b000, b_r} + {5'b0, cin_r & FULL_ON};
        OP_MUL:
          out_next = {3'b000, a_r} * {3'b000, b_r};
        OP_SHIFT:
          out_next = direction_r ? {out[4:0], serial_in_r} : {serial_in_r, out[5:1]};
        OP_ROTATE:
          out_next = direction_r ? {out[4:0], out[5]} : {out[0], out[5:1]};
        default:
          out_next = out;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out  <= '0;
      leds <= '0;
    end else begin
      out  <= out_next;
      leds <= leds_next;
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// Bench for alu_core: table of vectors with hand-derived results fed through a
// scoreboard queue, plus reset and mid-operation reset sequences.
module tb_alu_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  A, B, opcode;
  logic        cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B;
  logic [5:0]  out_a, out_b;
  logic [15:0] leds_a, leds_b;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  // dut_a: priority A, full adder; dut_b: priority B, carry ignored
  alu_core #(.INPUT_PRIORITY("A"), .FULL_ADDER("ON")) dut_a (
    .clk(clk), .rst(rst), .A(A), .B(B), .opcode(opcode), .cin(cin),
    .serial_in(serial_in), .direction(direction), .red_op_A(red_op_A),
    .red_op_B(red_op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
    .out(out_a), .leds(leds_a)
  );

  alu_core #(.INPUT_PRIORITY("B"), .FULL_ADDER("OFF")) dut_b (
    .clk(clk), .rst(rst), .A(A), .B(B), .opcode(opcode), .cin(cin),
    .serial_in(serial_in), .direction(direction), .red_op_A(red_op_A),
    .red_op_B(red_op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
    .out(out_b), .leds(leds_b)
  );

  typedef struct {
    string       name;
    logic [2:0]  a, b, op;
    logic        cin, si, dir, ra, rb, ba, bb;
    logic [5:0]  exp_a, exp_b;
    logic [15:0] exp_leds;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(string name, logic [2:0] a, logic [2:0] b, logic [2:0] op,
                              logic c, logic si, logic dir, logic ra, logic rb,
                              logic ba, logic bb, logic [5:0] ea, logic [5:0] eb,
                              logic [15:0] el);
    vec_t v;
    v.name = name; v.a = a; v.b = b; v.op = op; v.cin = c; v.si = si; v.dir = dir;
    v.ra = ra; v.rb = rb; v.ba = ba; v.bb = bb;
    v.exp_a = ea; v.exp_b = eb; v.exp_leds = el;
    return v;
  endfunction

  task automatic chk6(string name, logic [5:0] act, logic [5:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%02h), expected %0d (0x%02h)", name, act, act, req, req);
    end
  endtask

  task automatic chk16(string name, logic [15:0] act, logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, req);
    end
  endtask

  task automatic drive(vec_t v);
    A = v.a; B = v.b; opcode = v.op; cin = v.cin; serial_in = v.si; direction = v.dir;
    red_op_A = v.ra; red_op_B = v.rb; bypass_A = v.ba; bypass_B = v.bb;
  endtask

  task automatic check_vec(vec_t v);
    chk6({v.name, ".out_a"}, out_a, v.exp_a);
    chk6({v.name, ".out_b"}, out_b, v.exp_b);
    chk16({v.name, ".leds_a"}, leds_a, v.exp_leds);
    chk16({v.name, ".leds_b"}, leds_b, v.exp_leds);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //                name      a  b  op cin si dir ra rb ba bb  exp_a exp_b leds
    tbl.push_back(mk("byp_a",    5, 0, 7, 0, 0, 0, 0, 0, 1, 0,  5,  5, 16'h0000));
    tbl.push_back(mk("byp_ab",   3, 6, 0, 0, 0, 0, 0, 0, 1, 1,  3,  6, 16'h0000));
    tbl.push_back(mk("red_and",  7, 0, 0, 0, 0, 0, 1, 0, 0, 0,  1,  1, 16'h0000));
    tbl.push_back(mk("red_xor",  0, 3, 1, 0, 0, 0, 0, 1, 0, 0,  0,  0, 16'h0000));
    tbl.push_back(mk("red_both", 1, 3, 1, 0, 0, 0, 1, 1, 0, 0,  1,  0, 16'h0000));
    tbl.push_back(mk("add_cin",  7, 7, 2, 1, 0, 0, 0, 0, 0, 0, 15, 14, 16'h0000));
    tbl.push_back(mk("mul_max",  7, 7, 3, 0, 0, 0, 0, 0, 0, 0, 49, 49, 16'h0000));
    tbl.push_back(mk("and",      6, 3, 0, 0, 0, 0, 0, 0, 0, 0,  2,  2, 16'h0000));
    tbl.push_back(mk("xor",      5, 3, 1, 0, 0, 0, 0, 0, 0, 0,  6,  6, 16'h0000));
    tbl.push_back(mk("add7",     3, 4, 2, 0, 0, 0, 0, 0, 0, 0,  7,  7, 16'h0000));
    tbl.push_back(mk("shl_si1",  0, 0, 4, 0, 1, 1, 0, 0, 0, 0, 15, 15, 16'h0000));
    tbl.push_back(mk("rotr",     0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 39, 39, 16'h0000));
    tbl.push_back(mk("rotl",     0, 0, 5, 0, 0, 1, 0, 0, 0, 0, 15, 15, 16'h0000));
    tbl.push_back(mk("shr_si1",  0, 0, 4, 0, 1, 0, 0, 0, 0, 0, 39, 39, 16'h0000));
    tbl.push_back(mk("shr_si0",  0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 19, 19, 16'h0000));
    tbl.push_back(mk("inv_op6",  3, 3, 6, 0, 0, 0, 0, 0, 0, 0,  0,  0, 16'hFFFF));
    tbl.push_back(mk("inv_red",  3, 3, 3, 0, 0, 0, 1, 0, 0, 0,  0,  0, 16'h0000));
    tbl.push_back(mk("inv_op7",  3, 3, 7, 0, 0, 0, 0, 0, 0, 0,  0,  0, 16'hFFFF));
    tbl.push_back(mk("xor_rec",  2, 3, 1, 0, 0, 0, 0, 0, 0, 0,  1,  1, 16'h0000));
    tbl.push_back(mk("byp_b",    1, 4, 7, 0, 0, 0, 0, 0, 0, 1,  4,  4, 16'h0000));
    tbl.push_back(mk("red_and0", 3, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0,  0, 16'h0000));
    tbl.push_back(mk("and77",    7, 7, 0, 0, 0, 0, 0, 0, 0, 0,  7,  7, 16'h0000));
    tbl.push_back(mk("add_nocin",7, 7, 2, 0, 0, 0, 0, 0, 0, 0, 14, 14, 16'h0000));
    tbl.push_back(mk("mul30",    5, 6, 3, 0, 0, 0, 0, 0, 0, 0, 30, 30, 16'h0000));
    tbl.push_back(mk("red_b_and",0, 7, 0, 0, 0, 0, 0, 1, 0, 0,  1,  1, 16'h0000));
    tbl.push_back(mk("shl_si0",  0, 0, 4, 0, 0, 1, 0, 0, 0, 0,  2,  2, 16'h0000));
    tbl.push_back(mk("rotl2",    0, 0, 5, 0, 0, 1, 0, 0, 0, 0,  4,  4, 16'h0000));

    // Reset held with random inputs: outputs must stay cleared
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      A = 3'($urandom); B = 3'($urandom); opcode = 3'($urandom);
      {cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B} = 7'($urandom);
      tick();
      chk6("rst.out_a", out_a, 6'd0);
      chk6("rst.out_b", out_b, 6'd0);
      chk16("rst.leds_a", leds_a, 16'h0000);
      chk16("rst.leds_b", leds_b, 16'h0000);
    end
    rst = 1'b1;

    // Pipelined vectors: expectation pushed at drive time, popped two edges later
    foreach (tbl[i]) begin
      drive(tbl[i]);
      sb.push_back(tbl[i]);
      tick();
      if (sb.size() == 2) check_vec(sb.pop_front());
    end
    tick();
    while (sb.size() > 0) check_vec(sb.pop_front());

    // Mid-operation reset: async clear, then out valid only at the second edge
    drive(mk("inv", 0, 0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000));
    tick();
    tick();
    chk16("pre_rst.leds_a", leds_a, 16'hFFFF);
    #3 rst = 1'b0;
    #1;
    chk6("async_rst.out_a", out_a, 6'd0);
    chk16("async_rst.leds_a", leds_a, 16'h0000);
    chk16("async_rst.leds_b", leds_b, 16'h0000);
    drive(mk("mul", 7, 7, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000));
    tick();
    rst = 1'b1;
    tick();
    chk6("rel_edge1.out_a", out_a, 6'd0);
    tick();
    chk6("rel_edge2.out_a", out_a, 6'd49);
    chk6("rel_edge2.out_b", out_b, 6'd49);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
